// File: rtl/mm_pkg.sv
// Shared types and constants for the Mastermind display/scoring path.
package mm_pkg;

    // Three-bit digit code: 0 = blank, 1..6 = colour, 7 = blank.
    typedef logic [2:0] digit_t;

    localparam digit_t DIGIT_BLANK = 3'd0;
    localparam digit_t DIGIT_MIN   = 3'd1;
    localparam digit_t DIGIT_MAX   = 3'd6;
    localparam int     NUM_PEGS    = 4;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        WAIT_FB = 2'd1,
        SHOW_FB = 2'd2,
        WIN     = 2'd3
    } state_t;

    // Next colour for a digit: 1..6 cycling, 6 wraps back to 1.
    function automatic digit_t next_digit(input digit_t d);
        digit_t r;
        if (d >= DIGIT_MAX) begin
            r = DIGIT_MIN;
        end else begin
            r = d + 3'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mm_blink_timer.sv
// Blink phase generator for the digit under the cursor.
// phase = 0 means the digit is visible, phase = 1 means it is hidden.
module mm_blink_timer #(
    parameter int BLINK_DIV = 12500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic phase
);
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0] cnt_r;

    // Half-period counter; toggles phase at the wrap, held idle when cleared or stopped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
            phase <= 1'b0;
        end else if (clear || !run) begin
            cnt_r <= '0;
            phase <= 1'b0;
        end else if (cnt_r == CNT_W'(BLINK_DIV - 1)) begin
            cnt_r <= '0;
            phase <= ~phase;
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/mm_guess_ctrl.sv
// Guess-entry sequencer: composes a four-digit guess from button pulses,
// blinks the cursor digit, hands the guess to the scorer and displays feedback.
module mm_guess_ctrl
    import mm_pkg::*;
#(
    parameter int BLINK_DIV = 12500000,
    parameter int FB_HOLD   = 100000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_inc,
    input  logic        btn_next,
    input  logic        btn_submit,
    input  logic        fb_valid,
    input  logic [2:0]  fb_exact,
    input  logic [2:0]  fb_partial,
    output logic [11:0] guess,
    output logic        guess_valid,
    output logic        won,
    output logic [2:0]  d3,
    output logic [2:0]  d2,
    output logic [2:0]  d1,
    output logic [2:0]  d0
);
    localparam int HOLD_W = (FB_HOLD > 1) ? $clog2(FB_HOLD) : 1;

    state_t                     state_r, state_s;
    digit_t [NUM_PEGS-1:0]      g_r, g_s;
    logic   [1:0]               cursor_r, cursor_s;
    logic   [2:0]               exact_r, exact_s;
    logic   [2:0]               partial_r, partial_s;
    logic   [HOLD_W-1:0]        hold_r, hold_s;
    logic                       guess_valid_s;
    logic                       blink_clear_s;
    logic                       blink_run_s;
    logic                       phase_s;
    logic                       hidden_s;
    logic                       any_btn_s;
    digit_t [NUM_PEGS-1:0]      d_s;
    digit_t [NUM_PEGS-1:0]      d_r;
    logic                       won_r;

    assign any_btn_s   = btn_inc | btn_next | btn_submit;
    assign blink_run_s = (state_r == ENTRY);

    mm_blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (blink_clear_s),
        .run     (blink_run_s),
        .phase   (phase_s)
    );

    // Next-state logic: button handling in ENTRY, feedback capture, hold timing.
    always_comb begin
        state_s       = state_r;
        g_s           = g_r;
        cursor_s      = cursor_r;
        exact_s       = exact_r;
        partial_s     = partial_r;
        hold_s        = hold_r;
        guess_valid_s = 1'b0;
        blink_clear_s = 1'b0;

        case (state_r)
            ENTRY: begin
                if (btn_submit) begin
                    // Submit dominates; simultaneous inc/next are dropped.
                    state_s       = WAIT_FB;
                    guess_valid_s = 1'b1;
                    blink_clear_s = 1'b1;
                end else begin
                    if (btn_inc) begin
                        g_s[cursor_r] = next_digit(g_r[cursor_r]);
                    end else begin
                        g_s = g_r;
                    end
                    if (btn_next) begin
                        cursor_s = cursor_r - 2'd1;
                    end else begin
                        cursor_s = cursor_r;
                    end
                    if (btn_inc || btn_next) begin
                        blink_clear_s = 1'b1;
                    end else begin
                        blink_clear_s = 1'b0;
                    end
                end
            end
            WAIT_FB: begin
                if (fb_valid) begin
                    exact_s   = fb_exact;
                    partial_s = fb_partial;
                    hold_s    = '0;
                    if (fb_exact == 3'd4) begin
                        state_s = WIN;
                    end else begin
                        state_s = SHOW_FB;
                    end
                end else begin
                    state_s = WAIT_FB;
                end
            end
            SHOW_FB: begin
                if (any_btn_s || (hold_r == HOLD_W'(FB_HOLD - 1))) begin
                    // Early exit consumes the button; digits kept, cursor to leftmost.
                    state_s  = ENTRY;
                    cursor_s = 2'd3;
                    hold_s   = '0;
                end else begin
                    hold_s = hold_r + {{(HOLD_W-1){1'b0}}, 1'b1};
                end
            end
            WIN: begin
                state_s = WIN;
            end
            default: begin
                state_s = ENTRY;
            end
        endcase
    end

    // The blink mask is suppressed on the cycle a button restarts the blink so the
    // pressed digit is shown immediately.
    assign hidden_s = phase_s && (state_s == ENTRY) && !blink_clear_s;

    // Display mux computed from next-state values so d* lands with the state change.
    always_comb begin
        d_s = g_s;
        case (state_s)
            SHOW_FB: begin
                d_s = {exact_s, DIGIT_BLANK, DIGIT_BLANK, partial_s};
            end
            ENTRY: begin
                for (int i = 0; i < NUM_PEGS; i++) begin
                    if (hidden_s && (cursor_s == 2'(i))) begin
                        d_s[i] = DIGIT_BLANK;
                    end else begin
                        d_s[i] = g_s[i];
                    end
                end
            end
            default: begin
                d_s = g_s;
            end
        endcase
    end

    // State and datapath registers, including all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ENTRY;
            g_r         <= {NUM_PEGS{DIGIT_MIN}};
            cursor_r    <= 2'd3;
            exact_r     <= 3'd0;
            partial_r   <= 3'd0;
            hold_r      <= '0;
            guess_valid <= 1'b0;
            won_r       <= 1'b0;
            d_r         <= {NUM_PEGS{DIGIT_MIN}};
        end else begin
            state_r     <= state_s;
            g_r         <= g_s;
            cursor_r    <= cursor_s;
            exact_r     <= exact_s;
            partial_r   <= partial_s;
            hold_r      <= hold_s;
            guess_valid <= guess_valid_s;
            won_r       <= (state_s == WIN);
            d_r         <= d_s;
        end
    end

    assign guess = g_r;
    assign won   = won_r;
    assign d3    = d_r[3];
    assign d2    = d_r[2];
    assign d1    = d_r[1];
    assign d0    = d_r[0];

endmodule

// File: tb/tb_mm_guess_ctrl.sv
// Self-checking bench for mm_guess_ctrl with short blink/hold parameters.
module tb_mm_guess_ctrl;

    logic        clk;
    logic        reset_n;
    logic        btn_inc, btn_next, btn_submit;
    logic        fb_valid;
    logic [2:0]  fb_exact, fb_partial;
    logic [11:0] guess;
    logic        guess_valid;
    logic        won;
    logic [2:0]  d3, d2, d1, d0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [11:0] exp_q[$];

    mm_guess_ctrl #(
        .BLINK_DIV (4),
        .FB_HOLD   (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_inc     (btn_inc),
        .btn_next    (btn_next),
        .btn_submit  (btn_submit),
        .fb_valid    (fb_valid),
        .fb_exact    (fb_exact),
        .fb_partial  (fb_partial),
        .guess       (guess),
        .guess_valid (guess_valid),
        .won         (won),
        .d3          (d3),
        .d2          (d2),
        .d1          (d1),
        .d0          (d0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] pack4(input int a, input int b, input int c, input int d);
        logic [11:0] r;
        r = {3'(a), 3'(b), 3'(c), 3'(d)};
        return r;
    endfunction

    function automatic logic [11:0] disp();
        return {d3, d2, d1, d0};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Drive buttons for one active edge; returns on the following negedge.
    task automatic pulse(input logic inc, input logic nxt, input logic sub);
        btn_inc    = inc;
        btn_next   = nxt;
        btn_submit = sub;
        @(posedge clk);
        @(negedge clk);
        btn_inc    = 1'b0;
        btn_next   = 1'b0;
        btn_submit = 1'b0;
    endtask

    task automatic fb_pulse(input logic [2:0] ex, input logic [2:0] pa);
        fb_valid   = 1'b1;
        fb_exact   = ex;
        fb_partial = pa;
        @(posedge clk);
        @(negedge clk);
        fb_valid   = 1'b0;
        fb_exact   = 3'd0;
        fb_partial = 3'd0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor: every guess_valid pulse must match a queued expectation.
    always @(negedge clk) begin
        if (reset_n && guess_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_guess_valid", {20'd0, guess}, 32'hFFFF_FFFF);
            end else begin
                check("guess_on_valid", {20'd0, guess}, {20'd0, exp_q.pop_front()});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] exp_d;
        int          seq_d3[6];
        reset_n    = 1'b0;
        btn_inc    = 1'b0;
        btn_next   = 1'b0;
        btn_submit = 1'b0;
        fb_valid   = 1'b0;
        fb_exact   = 3'd0;
        fb_partial = 3'd0;
        repeat (2) @(negedge clk);

        // Reset values.
        check("rst_disp", {20'd0, disp()}, {20'd0, pack4(1, 1, 1, 1)});
        check("rst_guess", {20'd0, guess}, {20'd0, pack4(1, 1, 1, 1)});
        check("rst_won", {31'd0, won}, 32'd0);
        check("rst_gv", {31'd0, guess_valid}, 32'd0);
        reset_n = 1'b1;

        // Idle blink: d3 visible 4 edges, hidden 4 edges, ...
        for (int k = 1; k <= 16; k++) begin
            step(1);
            exp_d = (((k - 1) / 4) % 2 == 0) ? pack4(1, 1, 1, 1) : pack4(0, 1, 1, 1);
            check($sformatf("blink_k%0d", k), {20'd0, disp()}, {20'd0, exp_d});
        end
        pulse(1'b0, 1'b1, 1'b0);
        check("next_visible", {20'd0, disp()}, {20'd0, pack4(1, 1, 1, 1)});
        step(4);
        check("next_still_visible", {20'd0, disp()}, {20'd0, pack4(1, 1, 1, 1)});
        step(1);
        check("cursor2_hidden", {20'd0, disp()}, {20'd0, pack4(1, 0, 1, 1)});

        // Increment wrap on digit 3.
        do_reset();
        seq_d3 = '{2, 3, 4, 5, 6, 1};
        for (int i = 0; i < 6; i++) begin
            pulse(1'b1, 1'b0, 1'b0);
            check($sformatf("inc_disp%0d", i), {20'd0, disp()}, {20'd0, pack4(seq_d3[i], 1, 1, 1)});
            check($sformatf("inc_guess%0d", i), {20'd0, guess}, {20'd0, pack4(seq_d3[i], 1, 1, 1)});
        end

        // Simultaneous inc+next, then submit dominating.
        do_reset();
        pulse(1'b1, 1'b1, 1'b0);
        check("incnext_disp", {20'd0, disp()}, {20'd0, pack4(2, 1, 1, 1)});
        exp_q.push_back(pack4(2, 1, 1, 1));
        pulse(1'b1, 1'b1, 1'b1);
        check("submit_disp", {20'd0, disp()}, {20'd0, pack4(2, 1, 1, 1)});
        step(1);
        check("submit_seen", exp_q.size(), 32'd0);
        check("gv_dropped", {31'd0, guess_valid}, 32'd0);

        // WAIT_FB ignores buttons and does not blink.
        pulse(1'b1, 1'b0, 1'b0);
        step(6);
        check("waitfb_hold", {20'd0, disp()}, {20'd0, pack4(2, 1, 1, 1)});

        // Feedback display for exactly 8 cycles.
        fb_pulse(3'd2, 3'd1);
        check("fb_disp_c0", {20'd0, disp()}, {20'd0, pack4(2, 0, 0, 1)});
        for (int c = 1; c < 8; c++) begin
            step(1);
            check($sformatf("fb_disp_c%0d", c), {20'd0, disp()}, {20'd0, pack4(2, 0, 0, 1)});
        end
        step(1);
        check("fb_return", {20'd0, disp()}, {20'd0, pack4(2, 1, 1, 1)});
        pulse(1'b1, 1'b0, 1'b0);
        check("cursor_back3", {20'd0, disp()}, {20'd0, pack4(3, 1, 1, 1)});

        // Early return from SHOW_FB consumes the button.
        exp_q.push_back(pack4(3, 1, 1, 1));
        pulse(1'b0, 1'b0, 1'b1);
        fb_pulse(3'd2, 3'd1);
        step(2);
        check("early_pre", {20'd0, disp()}, {20'd0, pack4(2, 0, 0, 1)});
        pulse(1'b1, 1'b0, 1'b0);
        check("early_ret", {20'd0, disp()}, {20'd0, pack4(3, 1, 1, 1)});
        check("early_guess", {20'd0, guess}, {20'd0, pack4(3, 1, 1, 1)});
        check("early_seen", exp_q.size(), 32'd0);

        // Win: steady display, all inputs ignored.
        exp_q.push_back(pack4(3, 1, 1, 1));
        pulse(1'b0, 1'b0, 1'b1);
        fb_pulse(3'd4, 3'd0);
        check("win_flag", {31'd0, won}, 32'd1);
        check("win_disp", {20'd0, disp()}, {20'd0, pack4(3, 1, 1, 1)});
        for (int r = 0; r < 20; r++) begin
            fb_valid   = 1'($urandom_range(0, 1));
            fb_exact   = 3'($urandom_range(0, 4));
            fb_partial = 3'($urandom_range(0, 4));
            pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            fb_valid   = 1'b0;
            check($sformatf("win_won%0d", r), {31'd0, won}, 32'd1);
            check($sformatf("win_stable%0d", r), {20'd0, disp()}, {20'd0, pack4(3, 1, 1, 1)});
        end
        reset_n = 1'b0;
        #1;
        check("win_rst_won", {31'd0, won}, 32'd0);
        check("win_rst_disp", {20'd0, disp()}, {20'd0, pack4(1, 1, 1, 1)});
        @(negedge clk);
        reset_n = 1'b1;

        // Reset while waiting for feedback; late feedback is ignored.
        exp_q.push_back(pack4(1, 1, 1, 1));
        pulse(1'b0, 1'b0, 1'b1);
        step(2);
        check("wait_seen", exp_q.size(), 32'd0);
        reset_n = 1'b0;
        #1;
        check("midrst_guess", {20'd0, guess}, {20'd0, pack4(1, 1, 1, 1)});
        check("midrst_gv", {31'd0, guess_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        fb_pulse(3'd4, 3'd0);
        check("late_fb_won", {31'd0, won}, 32'd0);
        pulse(1'b1, 1'b0, 1'b0);
        check("late_fb_entry", {20'd0, disp()}, {20'd0, pack4(2, 1, 1, 1)});
        step(3);
        check("final_queue", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
